// File: rtl/nco_sweep_pkg.sv
// Shared definitions for the NCO frequency-sweep controller.
//   state_t  : controller states (IDLE, STEP, DONE)
//   APR_DEF  : default phase-increment width
//   DWW_DEF  : default dwell-count width
package nco_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int APR_DEF = 32;
    localparam int DWW_DEF = 16;

endpackage

// File: rtl/nco_sweep_dwell.sv
// Dwell down-counter for the sweep controller.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value loaded at the start of each sweep point
//   dec        : decrement by one (saturates at zero)
//   zero       : counter currently reads zero
module nco_sweep_dwell #(
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [DWW-1:0] load_val,
    input  logic           dec,
    output logic           zero
);

    logic [DWW-1:0] cnt_q;
    logic [DWW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep controller driving an NCO phase increment.
//   clk, reset          : clock, synchronous active-high reset
//   start, abort, cont  : sweep request, terminate, continuous-repeat mode
//   f_start/f_stop      : first/last phase increment
//   f_step, dwell       : step magnitude, extra hold cycles per point
//   phi_inc_o           : phase increment to the NCO
//   nco_clken           : NCO clock enable (high only while sweeping)
//   step_stb            : one-cycle pulse on every new phi_inc_o value
//   busy, done          : sweep in progress / one-cycle end-of-sweep pulse
// All outputs are registered.
module nco_sweep_ctrl
    import nco_sweep_pkg::*;
#(
    parameter int APR = APR_DEF,
    parameter int DWW = DWW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic           cont,
    input  logic [APR-1:0] f_start,
    input  logic [APR-1:0] f_stop,
    input  logic [APR-1:0] f_step,
    input  logic [DWW-1:0] dwell,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken,
    output logic           step_stb,
    output logic           busy,
    output logic           done
);

    state_t         state_q, state_d;
    logic [APR-1:0] phi_q, phi_d;
    logic           stb_q, stb_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           clken_q, clken_d;

    // Shadow copies of the sweep setup, captured when the sweep starts.
    logic [APR-1:0] start_sh_q, start_sh_d;
    logic [APR-1:0] stop_sh_q, stop_sh_d;
    logic [APR-1:0] step_sh_q, step_sh_d;
    logic [DWW-1:0] dwell_sh_q, dwell_sh_d;
    logic           cont_sh_q, cont_sh_d;
    logic           up_q, up_d;

    logic           dw_load, dw_dec, dw_zero;
    logic [DWW-1:0] dw_val;

    // One extra bit catches carry/borrow so the sweep never wraps.
    logic [APR:0]   sum_w, diff_w;
    logic [APR-1:0] next_val;

    nco_sweep_dwell #(.DWW(DWW)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (dw_load),
        .load_val (dw_val),
        .dec      (dw_dec),
        .zero     (dw_zero)
    );

    always_comb begin
        sum_w  = {1'b0, phi_q} + {1'b0, step_sh_q};
        diff_w = {1'b0, phi_q} - {1'b0, step_sh_q};
        if (up_q) begin
            next_val = (sum_w[APR] || (sum_w[APR-1:0] > stop_sh_q)) ? stop_sh_q : sum_w[APR-1:0];
        end else begin
            next_val = (diff_w[APR] || (diff_w[APR-1:0] < stop_sh_q)) ? stop_sh_q : diff_w[APR-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        phi_d      = phi_q;
        stb_d      = 1'b0;
        done_d     = 1'b0;
        start_sh_d = start_sh_q;
        stop_sh_d  = stop_sh_q;
        step_sh_d  = step_sh_q;
        dwell_sh_d = dwell_sh_q;
        cont_sh_d  = cont_sh_q;
        up_d       = up_q;
        dw_load    = 1'b0;
        dw_dec     = 1'b0;
        dw_val     = dwell_sh_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    start_sh_d = f_start;
                    // A zero step can never reach f_stop, so collapse the
                    // sweep to the single point f_start.
                    stop_sh_d  = (f_step == '0) ? f_start : f_stop;
                    step_sh_d  = f_step;
                    dwell_sh_d = dwell;
                    cont_sh_d  = cont;
                    up_d       = (f_start <= f_stop);
                    phi_d      = f_start;
                    stb_d      = 1'b1;
                    dw_load    = 1'b1;
                    dw_val     = dwell;
                    state_d    = ST_STEP;
                end
            end
            ST_STEP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dw_zero) begin
                    if (phi_q == stop_sh_q) begin
                        if (cont_sh_q) begin
                            phi_d   = start_sh_q;
                            stb_d   = 1'b1;
                            dw_load = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        phi_d   = next_val;
                        stb_d   = 1'b1;
                        dw_load = 1'b1;
                    end
                end else begin
                    dw_dec = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d == ST_STEP);
        clken_d = (state_d == ST_STEP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phi_q      <= '0;
            stb_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clken_q    <= 1'b0;
            start_sh_q <= '0;
            stop_sh_q  <= '0;
            step_sh_q  <= '0;
            dwell_sh_q <= '0;
            cont_sh_q  <= 1'b0;
            up_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phi_q      <= phi_d;
            stb_q      <= stb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clken_q    <= clken_d;
            start_sh_q <= start_sh_d;
            stop_sh_q  <= stop_sh_d;
            step_sh_q  <= step_sh_d;
            dwell_sh_q <= dwell_sh_d;
            cont_sh_q  <= cont_sh_d;
            up_q       <= up_d;
        end
    end

    assign phi_inc_o = phi_q;
    assign nco_clken = clken_q;
    assign step_stb  = stb_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: stimulus pushes expected
// step/done events (value and cycle stamp); a monitor pops and compares.
module tb_nco_sweep_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cont = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [31:0] phi_inc_o;
    logic        nco_clken;
    logic        step_stb;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] exp_phi = '0;

    typedef struct {
        bit          is_done;
        logic [31:0] val;
        int          cyc;
    } ev_t;
    ev_t q[$];

    nco_sweep_ctrl #(.APR(32), .DWW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cont      (cont),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .phi_inc_o (phi_inc_o),
        .nco_clken (nco_clken),
        .step_stb  (step_stb),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_step(input logic [31:0] v, input int c);
        ev_t e;
        e.is_done = 1'b0; e.val = v; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic exp_done(input int c);
        ev_t e;
        e.is_done = 1'b1; e.val = '0; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic check_ev(input bit is_done, input logic [31:0] v);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %s val %h at cycle %0d, required none",
                     is_done ? "done" : "step", v, cyc);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 32'(is_done), 32'(e.is_done));
            chk("ev_cycle", cyc, e.cyc);
            if (!is_done) begin
                chk("ev_value", v, e.val);
                exp_phi = e.val;
            end
            $display("event %s val=%h cycle=%0d", is_done ? "done" : "step", v, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from register updates.
    always @(negedge clk) begin
        if (step_stb === 1'b1) begin
            check_ev(1'b0, phi_inc_o);
            chk("stb_clken", {31'd0, nco_clken}, 32'd1);
        end
        if (done === 1'b1) begin
            check_ev(1'b1, '0);
            chk("done_busy_clken", {30'd0, busy, nco_clken}, 32'd0);
        end
        if (busy === 1'b1) begin
            chk("phi_hold", phi_inc_o, exp_phi);
        end
    end

    // Sets up and raises start at a falling edge; returns the cycle stamp
    // at which the first point appears. Caller pushes events, then release().
    task automatic issue(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [15:0] dw, input logic c, output int s);
        @(negedge clk);
        f_start = fs; f_stop = fe; f_step = st; dwell = dw; cont = c;
        start = 1'b1;
        s = cyc + 1;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic up_sweep(input bit poke_start);
        int s;
        issue(100, 130, 10, 2, 1'b0, s);
        exp_step(100, s); exp_step(110, s + 3); exp_step(120, s + 6); exp_step(130, s + 9);
        exp_done(s + 12);
        release_start();
        if (poke_start) begin
            // New setup and a start mid-sweep must both be ignored.
            @(negedge clk);
            f_start = 7; f_stop = 9; f_step = 1; dwell = 0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain();
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        chk("rst_phi", phi_inc_o, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_clken", {31'd0, nco_clken}, 32'd0);
        chk("rst_stb", {31'd0, step_stb}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        // Up sweep, with a stray start mid-sweep
        up_sweep(1'b1);

        // Clamp to f_stop
        issue(100, 125, 10, 0, 1'b0, s);
        exp_step(100, s); exp_step(110, s + 1); exp_step(120, s + 2); exp_step(125, s + 3);
        exp_done(s + 4);
        release_start();
        drain();

        // Carry clamp at top of range
        issue(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 1'b0, s);
        exp_step(32'hFFFF_FFF0, s); exp_step(32'hFFFF_FFFF, s + 1);
        exp_done(s + 2);
        release_start();
        drain();

        // Down sweep
        issue(32'h1000, 32'h0F00, 32'h80, 1, 1'b0, s);
        exp_step(32'h1000, s); exp_step(32'h0F80, s + 2); exp_step(32'h0F00, s + 4);
        exp_done(s + 6);
        release_start();
        drain();

        // Continuous, then abort during a 20 point
        issue(10, 30, 10, 0, 1'b1, s);
        exp_step(10, s);     exp_step(20, s + 1); exp_step(30, s + 2);
        exp_step(10, s + 3); exp_step(20, s + 4); exp_step(30, s + 5);
        exp_step(10, s + 6); exp_step(20, s + 7);
        release_start();
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_phi", phi_inc_o, 32'd20);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_clken", {31'd0, nco_clken}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        drain();

        // Reset during the 110 point
        issue(100, 130, 10, 2, 1'b0, s);
        exp_step(100, s); exp_step(110, s + 3);
        release_start();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_phi", phi_inc_o, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_clken", {31'd0, nco_clken}, 32'd0);
        chk("mid_rst_stb", {31'd0, step_stb}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        drain();
        up_sweep(1'b0);

        // start together with abort in IDLE: no response
        @(negedge clk);
        f_start = 55; f_stop = 66; f_step = 1; dwell = 0; cont = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("start_abort_busy2", {31'd0, busy}, 32'd0);
        chk("idle_phi_hold", phi_inc_o, 32'd130);

        // Zero step: single point held dwell+1 cycles
        issue(500, 900, 0, 4, 1'b0, s);
        exp_step(500, s);
        exp_done(s + 5);
        release_start();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, required finish");
        $fatal(1, "timeout");
    end

endmodule
